// File: rtl/b_block.sv
// b_block: five-replica majority voter with fault injection and error tracking.
// Ports: clk, rst, x, g1..g5 in; A, mismatch[4:0], err, fail, bad[4:0], err_cnt out.
module b_block #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             g1,
  input  logic             g2,
  input  logic             g3,
  input  logic             g4,
  input  logic             g5,
  output logic             A,
  output logic [4:0]       mismatch,
  output logic             err,
  output logic             fail,
  output logic [4:0]       bad,
  output logic [CNT_W-1:0] err_cnt
);

  logic [4:0] g;
  logic [4:0] r;
  logic [4:0] diff;
  logic [2:0] n_one;
  logic [2:0] n_flt;
  logic       vote;
  logic       any;

  assign g = {g5, g4, g3, g2, g1};
  assign r = {5{x}} ^ g;

  assign n_one = {2'b0, r[0]} + {2'b0, r[1]}
               + {2'b0, r[2]} + {2'b0, r[3]}
               + {2'b0, r[4]};

  assign n_flt = {2'b0, g[0]} + {2'b0, g[1]}
               + {2'b0, g[2]} + {2'b0, g[3]}
               + {2'b0, g[4]};

  assign vote = (n_one >= 3'd3);
  assign diff = r ^ {5{vote}};
  assign any  = |diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      A        <= 1'b0;
      mismatch <= '0;
      err      <= 1'b0;
      fail     <= 1'b0;
      bad      <= '0;
      err_cnt  <= '0;
    end else begin
      A        <= vote;
      mismatch <= diff;
      err      <= any;
      fail     <= (n_flt >= 3'd3);
      bad      <= bad | diff;
      // counts the current-cycle condition, saturating at all-ones
      if (any && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_b_block.sv
// tb_b_block: directed and random checks of b_block against a rule model.
// Two instances share stimulus: default CNT_W and CNT_W=2 for saturation.
module tb_b_block;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic [4:0] gv;

  logic       a8, err8, fail8;
  logic [4:0] mis8, bad8;
  logic [7:0] cnt8;
  logic       a2, err2, fail2;
  logic [4:0] mis2, bad2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  logic       m_a, m_err, m_fail;
  logic [4:0] m_mis, m_bad;
  int         m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  b_block dut8 (
    .clk(clk), .rst(rst), .x(x),
    .g1(gv[0]), .g2(gv[1]), .g3(gv[2]),
    .g4(gv[3]), .g5(gv[4]),
    .A(a8), .mismatch(mis8), .err(err8),
    .fail(fail8), .bad(bad8), .err_cnt(cnt8)
  );

  b_block #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x),
    .g1(gv[0]), .g2(gv[1]), .g3(gv[2]),
    .g4(gv[3]), .g5(gv[4]),
    .A(a2), .mismatch(mis2), .err(err2),
    .fail(fail2), .bad(bad2), .err_cnt(cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Model written from the fault-count rules, not from a vote circuit.
  task automatic model_edge();
    int k;
    if (rst) begin
      m_a = 0; m_mis = 0; m_err = 0;
      m_fail = 0; m_bad = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      k = $countones(gv);
      if (k <= 2) begin
        m_a   = x;
        m_mis = gv;
      end else begin
        m_a   = ~x;
        m_mis = ~gv;
      end
      m_err  = (m_mis != 0);
      m_fail = (k >= 3);
      m_bad  = m_bad | m_mis;
      if (m_err) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".A"},    {31'd0, a8},    {31'd0, m_a});
    chk({tag, ".mis"},  {27'd0, mis8},  {27'd0, m_mis});
    chk({tag, ".err"},  {31'd0, err8},  {31'd0, m_err});
    chk({tag, ".fail"}, {31'd0, fail8}, {31'd0, m_fail});
    chk({tag, ".bad"},  {27'd0, bad8},  {27'd0, m_bad});
    chk({tag, ".cnt"},  {24'd0, cnt8},  m_cnt8);
    chk({tag, ".A2"},   {31'd0, a2},    {31'd0, m_a});
    chk({tag, ".mis2"}, {27'd0, mis2},  {27'd0, m_mis});
    chk({tag, ".bad2"}, {27'd0, bad2},  {27'd0, m_bad});
    chk({tag, ".cnt2"}, {30'd0, cnt2},  m_cnt2);
  endtask

  task automatic step(input logic r_i,
                      input logic x_i,
                      input logic [4:0] g_i,
                      input string tag);
    rst = r_i;
    x   = x_i;
    gv  = g_i;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic px;
    rst = 1'b1; x = 1'b0; gv = 5'b0;
    m_bad = 0; m_cnt8 = 0; m_cnt2 = 0;

    step(1, 0, 5'b00000, "rst0");
    step(1, 0, 5'b00000, "rst1");
    chk("rst.A_lit",   {31'd0, a8},   0);
    chk("rst.cnt_lit", {24'd0, cnt8}, 0);

    step(0, 0, 5'b00100, "g3_x0");
    chk("g3.mis_lit", {27'd0, mis8}, 32'b00100);
    chk("g3.cnt_lit", {24'd0, cnt8}, 1);

    step(0, 1, 5'b00100, "g3_x1");
    chk("g3x1.A_lit", {31'd0, a8}, 1);
    step(0, 1, 5'b00000, "clean");
    chk("clean.bad_lit", {27'd0, bad8}, 32'b00100);

    step(0, 1, 5'b01011, "three");
    chk("three.mis_lit",  {27'd0, mis8}, 32'b10100);
    chk("three.fail_lit", {31'd0, fail8}, 1);

    step(0, 0, 5'b11111, "all5");
    chk("all5.err_lit", {31'd0, err8}, 0);
    step(0, 1, 5'b11111, "all5b");

    step(1, 0, 5'b00000, "rst2");
    for (int i = 0; i < 6; i++)
      step(0, i[0], 5'b00001, "sat");
    chk("sat.cnt2_lit", {30'd0, cnt2}, 3);
    chk("sat.cnt8_lit", {24'd0, cnt8}, 6);
    step(1, 1, 5'b00001, "rst3");
    chk("rst3.cnt2_lit", {30'd0, cnt2}, 0);
    chk("rst3.bad_lit",  {27'd0, bad8}, 0);

    px = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(0, ~px, 5'b00000, "tog");
      chk("tog.A_lit", {31'd0, a8}, {31'd0, ~px});
      px = ~px;
    end

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 39) == 0),
           1'($urandom),
           5'($urandom),
           "rand");

    // long error run saturates the wide counter too
    for (int i = 0; i < 260; i++)
      step(0, 1'($urandom), 5'b00010, "sat8");
    chk("sat8.cnt_lit", {24'd0, cnt8}, 255);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/b_block.md
B_BLOCK -- requirements
Module: b_block

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating error-event counter.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 x  input  1  golden data bit fed to all five replicas.
REQ-006 g1..g5  input  1 each  per-replica fault-injection controls: gi=1 inverts replica i.
REQ-007 A  output  1  registered 5-way majority-voted result.
REQ-008 mismatch  output  5  registered per-replica disagreement with the vote, bit i-1 = replica i.
REQ-009 err  output  1  registered flag: at least one replica disagrees with the vote.
REQ-010 fail  output  1  registered flag: three or more faults are injected, so the vote is corrupted.
REQ-011 bad  output  5  sticky per-replica flag: replica has ever disagreed since reset.
REQ-012 err_cnt  output  CNT_W  saturating count of cycles with err=1.

Function
REQ-013 Replica value ri = x XOR gi, i=1..5, evaluated combinationally each cycle.
REQ-014 vote = 1 when at least 3 of r1..r5 are 1, else 0.
REQ-015 At each rising clk edge with rst=0, A <= vote, giving 1-cycle latency from the inputs.
REQ-016 At the same edge, mismatch[i-1] <= ri XOR vote.
REQ-017 At the same edge, err <= OR of (ri XOR vote).
REQ-018 fail <= 1 when popcount(g1..g5) >= 3, else 0, updated every cycle.
REQ-019 bad[i-1] <= bad[i-1] OR (ri XOR vote), and stays set until reset.
REQ-020 err_cnt increments by 1 on each edge where the current-cycle err condition is 1.
REQ-021 err_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-022 Faults 0..2: A equals x and mismatch equals {g5..g1}.
REQ-023 Faults 3..5: A equals NOT x, mismatch equals the inverse of {g5..g1}, and fail=1.
REQ-024 All five g=1: A = NOT x, mismatch=0, err=0, fail=1; this condition is not counted in err_cnt.
REQ-025 There is no handshake; every cycle is a valid sample.
REQ-026 All outputs are driven directly from registers, with no combinational paths from input to output.

Reset
REQ-027 When rst=1 at a clk edge, A, mismatch, err, fail, bad and err_cnt SHALL all be set to 0.
REQ-028 Reset takes priority over all updates in the same cycle.
REQ-029 Reset asserted mid-operation clears the sticky bad flags and err_cnt.
REQ-030 The first post-reset sample is taken at the first edge with rst=0.

Verification
REQ-031 rst=1 for 2 cycles, x=0, g=00000, then release -> A=0, mismatch=0, err=0, fail=0, err_cnt=0.
REQ-032 x=0, g3=1 (others 0), 1 cycle -> A=0, mismatch=00100, err=1, fail=0, err_cnt=1, bad=00100.
REQ-033 x=1, g3=1 -> A=1, mismatch=00100, err=1, err_cnt=2; then x=1, g=00000 -> A=1, err=0, bad still 00100.
REQ-034 x=1, g1=g2=g4=1 -> A=0, fail=1, mismatch=10100 (replicas 3 and 5 disagree), err=1.
REQ-035 CNT_W=2 with g1=1 held 6 cycles -> err_cnt reaches 3 and holds; assert rst for 1 cycle -> all outputs 0.
REQ-036 x toggles every cycle with g=00000 -> A follows x delayed by exactly one cycle.
